// File: rtl/fp32_div_pkg.sv
// Shared types and helpers for the FP32 divider request sequencer.
//   div_seq_state_e   : sequencer FSM states
//   FP32_*            : IEEE-754 single-precision field widths
//   fp32_is_zero_mag  : true when the magnitude (sign ignored) is zero
package fp32_div_pkg;

   localparam int unsigned FP32_EXP_W = 8;
   localparam int unsigned FP32_MAN_W = 23;
   localparam int unsigned FP32_W     = 1 + FP32_EXP_W + FP32_MAN_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } div_seq_state_e;

   // +0 and -0 both count as a zero divisor
   function automatic logic fp32_is_zero_mag(input logic [FP32_W-1:0] v);
      return (v[FP32_W-2:0] == '0);
   endfunction

endpackage

// File: rtl/fp32_req_fifo.sv
// Synchronous request FIFO with occupancy count.
//   clk_i, rstn_i : clock, async active-low reset (pointers/count only)
//   push_i/din_i  : write; caller guarantees not full
//   pop_i         : drop head; caller guarantees not empty
//   rd_data_c     : current head entry (combinational read)
//   count_o       : registered occupancy
//   full_c/empty_c: decoded from count_o
module fp32_req_fifo #(
   parameter int unsigned WIDTH = 68,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           din_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rd_data_c,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_c,
   output logic                       empty_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage needs no reset; validity is tracked by the count
   always_ff @(posedge clk_i) begin
      if (push_i) r_mem[r_wr_ptr] <= din_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push_i) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign rd_data_c = r_mem[r_rd_ptr];
   assign count_o   = r_count;
   assign full_c    = (r_count == CNT_W'(DEPTH));
   assign empty_c   = (r_count == '0);

endmodule

// File: rtl/fp32_div_sequencer.sv
// Flow-controlled front end for the single-outstanding FP32 divider.
//   req_*  : tagged request valid/ready input, buffered in a FIFO
//   div_*  : one-cycle start pulse + held operands to the divider, done/result back
//   rsp_*  : quotient, tag, divide-by-zero and watchdog flags, valid/ready output
//   busy_o : FSM active or work queued;  count_o : FIFO occupancy
module fp32_div_sequencer
   import fp32_div_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [FP32_W-1:0]          req_a_i,
   input  logic [FP32_W-1:0]          req_b_i,
   input  logic [TAG_W-1:0]           req_tag_i,
   output logic                       div_valid_o,
   output logic [FP32_W-1:0]          div_a_o,
   output logic [FP32_W-1:0]          div_b_o,
   input  logic [FP32_W-1:0]          div_result_i,
   input  logic                       div_done_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [FP32_W-1:0]          rsp_result_o,
   output logic [TAG_W-1:0]           rsp_tag_o,
   output logic                       rsp_dbz_o,
   output logic                       rsp_timeout_o,
   output logic                       busy_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned ENTRY_W = TAG_W + 2 * FP32_W;
   localparam int unsigned WD_W    = $clog2(TIMEOUT);

   div_seq_state_e r_state, w_next;

   logic [ENTRY_W-1:0] w_head;
   logic               w_full, w_empty, w_push, w_pop;
   logic               w_cap_done, w_cap_to;

   logic [WD_W-1:0]    r_wd;
   logic [FP32_W-1:0]  r_a, r_b, r_result;
   logic [TAG_W-1:0]   r_tag;
   logic               r_dbz, r_to, r_div_valid, r_rsp_valid;

   assign w_push = req_valid_i & ~w_full;

   fp32_req_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .push_i    (w_push),
      .din_i     ({req_tag_i, req_a_i, req_b_i}),
      .pop_i     (w_pop),
      .rd_data_c (w_head),
      .count_o   (count_o),
      .full_c    (w_full),
      .empty_c   (w_empty)
   );

   // State register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next state, FIFO pop and response capture strobes
   always_comb begin
      w_next     = r_state;
      w_pop      = 1'b0;
      w_cap_done = 1'b0;
      w_cap_to   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: w_next = S_WAIT;
         S_WAIT: begin
            // done takes priority over a coincident watchdog expiry
            if (div_done_i) begin
               w_cap_done = 1'b1;
               w_next     = S_HOLD;
            end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
               w_cap_to = 1'b1;
               w_next   = S_HOLD;
            end
         end
         S_HOLD: begin
            if (rsp_ready_i) begin
               if (!w_empty) begin
                  w_pop  = 1'b1;
                  w_next = S_ISSUE;
               end else begin
                  w_next = S_IDLE;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operand, watchdog and response registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wd        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_tag       <= '0;
         r_dbz       <= 1'b0;
         r_result    <= '0;
         r_to        <= 1'b0;
         r_div_valid <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_div_valid <= (w_next == S_ISSUE);
         r_rsp_valid <= (w_next == S_HOLD);
         if (w_pop) begin
            r_tag <= w_head[ENTRY_W-1 -: TAG_W];
            r_a   <= w_head[2*FP32_W-1 -: FP32_W];
            r_b   <= w_head[FP32_W-1:0];
            r_dbz <= fp32_is_zero_mag(w_head[FP32_W-1:0]);
         end
         if (r_state == S_ISSUE)     r_wd <= '0;
         else if (r_state == S_WAIT) r_wd <= r_wd + WD_W'(1);
         if (w_cap_done) begin
            r_result <= div_result_i;
            r_to     <= 1'b0;
         end else if (w_cap_to) begin
            r_result <= '0;
            r_to     <= 1'b1;
         end
      end
   end

   assign req_ready_o   = ~w_full;
   assign div_valid_o   = r_div_valid;
   assign div_a_o       = r_a;
   assign div_b_o       = r_b;
   assign rsp_valid_o   = r_rsp_valid;
   assign rsp_result_o  = r_result;
   assign rsp_tag_o     = r_tag;
   assign rsp_dbz_o     = r_dbz;
   assign rsp_timeout_o = r_to;
   assign busy_o        = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_fp32_div_sequencer.sv
// Directed + randomized bench for fp32_div_sequencer with a behavioural
// divider model and an in-order response scoreboard.
module tb_fp32_div_sequencer;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TAG_W   = 4;
   localparam int unsigned TIMEOUT = 64;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        req_valid_i, req_ready_o;
   logic [31:0] req_a_i, req_b_i;
   logic [3:0]  req_tag_i;
   logic        div_valid_o;
   logic [31:0] div_a_o, div_b_o, div_result_i;
   logic        div_done_i;
   logic        rsp_valid_o, rsp_ready_i;
   logic [31:0] rsp_result_o;
   logic [3:0]  rsp_tag_o;
   logic        rsp_dbz_o, rsp_timeout_o, busy_o;
   logic [2:0]  count_o;

   always #5 clk_i = ~clk_i;

   fp32_div_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
      .div_valid_o(div_valid_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
      .div_result_i(div_result_i), .div_done_i(div_done_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o),
      .rsp_dbz_o(rsp_dbz_o), .rsp_timeout_o(rsp_timeout_o),
      .busy_o(busy_o), .count_o(count_o)
   );

   // Quotient the divider model returns: exact for the known case, zero for a
   // zero divisor, otherwise an arbitrary operand-dependent pattern.
   function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b);
      if (b[30:0] == 31'd0) return 32'h0;
      if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
      return a ^ {b[15:0], b[31:16]} ^ 32'h1;
   endfunction

   // Divider model: latches operands on the start pulse, answers after a latency
   int          lat_fixed = 2;
   logic        lat_rand  = 1'b0;
   logic        next_hang = 1'b0;
   logic        spur_done = 1'b0;
   logic        m_busy, m_hang, m_done;
   int          m_cnt;
   logic [31:0] m_a, m_b, m_res;

   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         m_busy <= 1'b0; m_hang <= 1'b0; m_done <= 1'b0;
         m_cnt  <= 0;    m_a <= '0; m_b <= '0; m_res <= '0;
      end else begin
         m_done <= 1'b0;
         if (div_valid_o) begin
            m_busy <= 1'b1;
            m_hang <= next_hang;
            m_cnt  <= lat_rand ? int'($urandom_range(0, 5)) : lat_fixed;
            m_a    <= div_a_o;
            m_b    <= div_b_o;
         end else if (m_busy && !m_hang) begin
            if (m_cnt == 0) begin
               m_done <= 1'b1;
               m_res  <= div_ref(m_a, m_b);
               m_busy <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   assign div_done_i   = m_done | spur_done;
   assign div_result_i = m_res;

   int n_issue = 0;
   always @(posedge clk_i) if (div_valid_o) n_issue++;

   typedef struct packed {
      logic [3:0]  tag;
      logic [31:0] res;
      logic        dbz;
      logic        to;
   } exp_t;
   exp_t sb[$];

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic to);
      int   w = 0;
      exp_t e;
      while (!req_ready_o && w < 200) begin @(negedge clk_i); w++; end
      chk("req_ready_wait", 64'(req_ready_o), 64'(1));
      req_valid_i = 1'b1; req_a_i = a; req_b_i = b; req_tag_i = tag;
      e.tag = tag;
      e.res = to ? 32'h0 : div_ref(a, b);
      e.dbz = (b[30:0] == 31'd0);
      e.to  = to;
      sb.push_back(e);
      @(negedge clk_i);
      req_valid_i = 1'b0;
   endtask

   task automatic recv(input int hold, input logic exp_next);
      int          w = 0;
      exp_t        e;
      logic [63:0] snap;
      while (!rsp_valid_o && w < 200) begin @(negedge clk_i); w++; end
      chk("rsp_valid_wait", 64'(rsp_valid_o), 64'(1));
      if (sb.size() == 0) begin
         chk("scoreboard_underflow", 64'(sb.size()), 64'(1));
         return;
      end
      e = sb.pop_front();
      chk("rsp_tag",     64'(rsp_tag_o),     64'(e.tag));
      chk("rsp_result",  64'(rsp_result_o),  64'(e.res));
      chk("rsp_dbz",     64'(rsp_dbz_o),     64'(e.dbz));
      chk("rsp_timeout", 64'(rsp_timeout_o), 64'(e.to));
      snap = 64'({rsp_valid_o, rsp_timeout_o, rsp_dbz_o, rsp_tag_o, rsp_result_o});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk_i);
         chk("rsp_stable", 64'({rsp_valid_o, rsp_timeout_o, rsp_dbz_o, rsp_tag_o, rsp_result_o}), snap);
         chk("no_issue_in_hold", 64'(div_valid_o), 64'(0));
      end
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      if (exp_next) chk("b2b_issue", 64'(div_valid_o), 64'(1));
   endtask

   initial begin
      int          base, w, n, k;
      logic [31:0] ra, rb;

      rstn_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
      req_a_i = '0; req_b_i = '0; req_tag_i = '0;
      repeat (3) @(negedge clk_i);

      // Reset state
      chk("rst_req_ready", 64'(req_ready_o),  64'(1));
      chk("rst_div_valid", 64'(div_valid_o),  64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid_o),  64'(0));
      chk("rst_busy",      64'(busy_o),       64'(0));
      chk("rst_count",     64'(count_o),      64'(0));
      chk("rst_data",      64'({rsp_result_o, div_a_o}), 64'(0));
      chk("rst_flags",     64'({rsp_tag_o, rsp_dbz_o, rsp_timeout_o}), 64'(0));
      rstn_i = 1'b1;
      @(negedge clk_i);

      // Single request: 6.0 / 2.0, tag 3
      lat_fixed = 2;
      base = n_issue;
      send(32'h40C00000, 32'h40000000, 4'd3, 1'b0);
      chk("t1_no_issue_yet", 64'(div_valid_o), 64'(0));
      chk("t1_count",        64'(count_o),     64'(1));
      chk("t1_busy",         64'(busy_o),      64'(1));
      @(negedge clk_i);
      chk("t1_issue_pulse",  64'(div_valid_o), 64'(1));
      chk("t1_operand_a",    64'(div_a_o),     64'(32'h40C00000));
      w = 0;
      while (!div_done_i && w < 100) begin @(negedge clk_i); w++; end
      chk("t1_done_seen",    64'(div_done_i),  64'(1));
      chk("t1_rsp_before_d", 64'(rsp_valid_o), 64'(0));
      @(negedge clk_i);
      chk("t1_rsp_after_d",  64'(rsp_valid_o), 64'(1));
      recv(0, 1'b0);
      repeat (2) @(negedge clk_i);
      chk("t1_one_pulse",    64'(n_issue - base), 64'(1));
      chk("t1_idle_busy",    64'(busy_o),         64'(0));

      // Fill with a slow divider: 4 queued + 1 in flight
      lat_fixed = 30;
      base = n_issue;
      for (int i = 0; i < 5; i++)
         send(32'h3F800000 + 32'(i), 32'h40000000 + 32'(i * 7), 4'(i + 8), 1'b0);
      chk("fill_ready_low", 64'(req_ready_o), 64'(0));
      chk("fill_count",     64'(count_o),     64'(4));
      for (int i = 0; i < 5; i++) recv(0, (i < 4) ? 1'b1 : 1'b0);
      chk("fill_issues",    64'(n_issue - base), 64'(5));

      // Divide by negative zero
      lat_fixed = 1;
      send(32'h3F800000, 32'h80000000, 4'd7, 1'b0);
      recv(0, 1'b0);

      // Response back-pressure for 10 cycles with work queued
      send(32'h41200000, 32'h40A00000, 4'd1, 1'b0);
      send(32'h41A00000, 32'h40800000, 4'd2, 1'b0);
      recv(10, 1'b1);
      recv(0, 1'b0);

      // Watchdog: first op never completes, second completes normally
      next_hang = 1'b1;
      send(32'h40400000, 32'h3F000000, 4'd5, 1'b1);
      send(32'h40800000, 32'h3F800000, 4'd6, 1'b0);
      w = 0;
      while (!div_valid_o && w < 200) begin @(negedge clk_i); w++; end
      chk("to_issue_seen", 64'(div_valid_o), 64'(1));
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
         if (n == 1) next_hang = 1'b0;
      end while (!rsp_valid_o && n < 300);
      chk("to_latency", 64'(n), 64'(TIMEOUT + 1));
      recv(0, 1'b1);
      recv(0, 1'b0);

      // Randomized batches
      lat_rand = 1'b1;
      for (int bt = 0; bt < 8; bt++) begin
         k = int'($urandom_range(1, 4));
         for (int i = 0; i < k; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ($urandom & 32'h80000000) : $urandom;
            send(ra, rb, 4'($urandom), 1'b0);
         end
         for (int i = 0; i < k; i++) recv(int'($urandom_range(0, 3)), 1'b0);
      end
      lat_rand = 1'b0;

      // Reset during WAIT with two requests queued
      lat_fixed = 40;
      send(32'h40000000, 32'h3F800000, 4'd9, 1'b0);
      send(32'h40000001, 32'h3F800000, 4'd10, 1'b0);
      send(32'h40000002, 32'h3F800000, 4'd11, 1'b0);
      repeat (4) @(negedge clk_i);
      chk("rst_mid_count_before", 64'(count_o), 64'(2));
      rstn_i = 1'b0;
      #1;
      chk("rst_mid_count",     64'(count_o),     64'(0));
      chk("rst_mid_rsp_valid", 64'(rsp_valid_o), 64'(0));
      chk("rst_mid_busy",      64'(busy_o),      64'(0));
      sb.delete();
      @(negedge clk_i);
      rstn_i = 1'b1;
      base = n_issue;
      @(negedge clk_i);
      spur_done = 1'b1;
      @(negedge clk_i);
      spur_done = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("spur_rsp_valid", 64'(rsp_valid_o),    64'(0));
      chk("spur_busy",      64'(busy_o),         64'(0));
      chk("spur_no_issue",  64'(n_issue - base), 64'(0));

      // Normal operation after reset
      lat_fixed = 3;
      send(32'h40C00000, 32'h40000000, 4'd12, 1'b0);
      recv(0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
